stream_demux_1xn: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on every port. It routes beats from one input stream to one of `N_CH` output channels and locks the route for the length of a packet. Packets addressed to a non-existent channel are dropped and counted. It sits between a single producer and a bank of per-channel consumers, and succeeds the combinational 1x4 demux.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_hold_reg.sv | 43 ++++
 rtl/stream_demux_1xn.sv | 119 +++++++++++
 tb/tb_stream_demux_1xn.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT  = 2'd1,
      DROP = 2'd2
   } route_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/stream_demux_hold_reg.sv
// One-entry holding register: accepts a new word on the same edge the held word drains.
module stream_demux_hold_reg #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with per-packet route lock and
// a saturating counter of beats dropped for addressing a missing channel.
module stream_demux_1xn
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4,
   parameter int CNT_W = 8,
   localparam int SEL_W = clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [SEL_W-1:0] in_sel,
   output logic [N_CH-1:0]  out_valid,
   input  logic [N_CH-1:0]  out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] drop_cnt
);

   route_state_t     state_q, state_d;
   logic [SEL_W-1:0] route_q, route_d;
   logic [SEL_W-1:0] hold_ch_q, hold_ch_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [SEL_W-1:0] dest_ch;
   logic [N_CH-1:0]  ch_onehot;
   logic [WIDTH:0]   hold_payload;
   logic             sel_invalid;
   logic             drop_beat;
   logic             accept;
   logic             hold_in_valid;
   logic             hold_in_ready;
   logic             hold_valid;
   logic             sel_ready;

   assign sel_invalid = int'(in_sel) >= N_CH;
   assign drop_beat   = (state_q == DROP) || ((state_q == IDLE) && sel_invalid);
   // Dropped beats bypass the hold register, so they never wait on a consumer.
   assign in_ready    = rst_n && (drop_beat || hold_in_ready);
   assign accept      = in_valid && in_ready;
   assign dest_ch     = (state_q == IDLE) ? in_sel : route_q;

   assign hold_in_valid = in_valid && !drop_beat;

   always_comb begin
      ch_onehot = '0;
      for (int k = 0; k < N_CH; k++) begin
         ch_onehot[k] = (int'(hold_ch_q) == k);
      end
   end

   assign sel_ready = |(ch_onehot & out_ready);
   assign out_valid = ch_onehot & {N_CH{hold_valid}};
   assign out_data  = hold_payload[WIDTH-1:0];
   assign out_last  = hold_payload[WIDTH];
   assign drop_cnt  = drop_cnt_q;

   stream_demux_hold_reg #(
      .W (WIDTH + 1)
   ) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (hold_in_valid),
      .in_ready  (hold_in_ready),
      .in_data   ({in_last, in_data}),
      .out_valid (hold_valid),
      .out_ready (sel_ready),
      .out_data  (hold_payload)
   );

   // The channel tag follows the word it belongs to, not the open route.
   always_comb begin
      hold_ch_d = hold_ch_q;
      if (accept && !drop_beat) hold_ch_d = dest_ch;
   end

   always_comb begin
      state_d = state_q;
      route_d = route_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               route_d = in_sel;
               if (!in_last) state_d = sel_invalid ? DROP : PKT;
            end
         end
         PKT, DROP: begin
            if (accept && in_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && drop_beat && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         route_q    <= '0;
         hold_ch_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         route_q    <= route_d;
         hold_ch_q  <= hold_ch_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Randomised and directed bench for stream_demux_1xn against a packet-level reference model.
module tb_stream_demux_1xn;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int CW = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic [SW-1:0] in_sel;
   logic [N-1:0]  out_ready;

   logic          in_ready;
   logic [N-1:0]  out_valid;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic [CW-1:0] drop_cnt;

   logic          s_in_ready;
   logic [N-1:0]  s_out_valid;
   logic [W-1:0]  s_out_data;
   logic          s_out_last;
   logic [1:0]    s_drop_cnt;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit         m_valid;
   int         m_ch;
   logic [7:0] m_data;
   bit         m_last;
   bit         m_open;
   int         m_route;
   int         m_drop;
   int         m_sat;
   bit         m_acc;

   always #5 clk = ~clk;

   stream_demux_1xn #(.WIDTH(W), .N_CH(N), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .drop_cnt(drop_cnt)
   );

   stream_demux_1xn #(.WIDTH(W), .N_CH(N), .CNT_W(2)) sat_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_last(s_out_last), .drop_cnt(s_drop_cnt)
   );

   function automatic bit exp_in_ready();
      bit dropping;
      if (!rst_n) return 1'b0;
      dropping = m_open ? (m_route >= N) : (int'(in_sel) >= N);
      return dropping || !m_valid || out_ready[m_ch];
   endfunction

   function automatic logic [29:0] exp_vec();
      logic [N-1:0] oh;
      oh = m_valid ? N'(1 << m_ch) : '0;
      return {exp_in_ready(), oh, m_valid ? m_last : 1'b0, m_valid ? m_data : 8'h00,
              CW'(m_drop), 2'(m_sat), oh};
   endfunction

   function automatic logic [29:0] obs_vec();
      bit v;
      v = |out_valid;
      return {in_ready, out_valid, v ? out_last : 1'b0, v ? out_data : 8'h00,
              drop_cnt, s_drop_cnt, s_out_valid};
   endfunction

   task automatic model_clear();
      m_valid = 0; m_ch = 0; m_data = 8'h00; m_last = 0;
      m_open = 0; m_route = 0; m_drop = 0; m_sat = 0; m_acc = 0;
   endtask

   // Advance one clock: update the model from the inputs seen at the edge, return at negedge.
   task automatic step();
      bit acc;
      @(posedge clk);
      acc = in_valid && exp_in_ready();
      m_acc = acc;
      if (m_valid && out_ready[m_ch]) m_valid = 0;
      if (acc) begin
         if (!m_open) m_route = int'(in_sel);
         if (m_route >= N) begin
            if (m_drop < 255) m_drop++;
            if (m_sat < 3) m_sat++;
         end else begin
            m_valid = 1; m_ch = m_route; m_data = in_data; m_last = in_last;
         end
         m_open = !in_last;
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit l, input int s);
      in_valid = v; in_data = d; in_last = l; in_sel = SW'(s);
   endtask

   task automatic do_reset();
      in_valid = 0;
      rst_n = 0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 1; out_ready = '1; drive(0, 8'h00, 0, 0);
      #2 rst_n = 0;
      model_clear();
      #1;
      tests++;
      if ({in_ready, out_valid, drop_cnt, s_drop_cnt} !== '0) begin
         fails++; $display("FAIL reset_init: got rdy=%b vld=%b cnt=%0d want all 0", in_ready, out_valid, drop_cnt);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      drive(1, 8'h11, 0, 1); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
         fails++; $display("FAIL reset_first_beat: got %h want %h", obs_vec(), exp_vec());
      end
      step();
      drive(1, 8'h12, 0, 3); #1;
      rst_n = 0;
      model_clear();
      #1;
      tests++;
      if ({in_ready, out_valid, out_data, out_last, drop_cnt} !== '0) begin
         fails++; $display("FAIL reset_mid_packet: got rdy=%b vld=%b data=%h last=%b cnt=%0d want all 0",
                           in_ready, out_valid, out_data, out_last, drop_cnt);
      end
      in_valid = 0;
      @(negedge clk);
      rst_n = 1;
      drive(1, 8'h5C, 1, 2); #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_restart_ready: got %b want 1", in_ready);
      end
      step();
      in_valid = 0; #1;
      tests++;
      if ({out_valid, out_data, out_last} !== {5'b00100, 8'h5C, 1'b1}) begin
         fails++; $display("FAIL reset_restart_route: got vld=%b data=%h last=%b want 00100 5c 1",
                           out_valid, out_data, out_last);
      end
      step();
   endtask

   task automatic test_route_lock();
      logic [7:0] data_q[$];
      bit         last_q[$];
      logic [7:0] bd[3] = '{8'hA1, 8'hA2, 8'hA3};
      int         bs[3] = '{1, 3, 3};
      do_reset();
      out_ready = '1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1, bd[i], i == 2, bs[i]); else drive(0, 8'h00, 0, 0);
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL route_lock_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         if (out_valid[1] && out_ready[1]) begin data_q.push_back(out_data); last_q.push_back(out_last); end
         step();
      end
      tests++;
      if (data_q.size() != 3 || data_q[0] !== 8'hA1 || data_q[1] !== 8'hA2 || data_q[2] !== 8'hA3
          || last_q[0] || last_q[1] || !last_q[2]) begin
         fails++; $display("FAIL route_lock_seq: got %0d beats on ch1 want A1 A2 A3 with last on A3", data_q.size());
      end
   endtask

   task automatic test_back_pressure();
      logic [7:0] sent[6];
      logic [7:0] got[$];
      logic [7:0] held;
      int idx = 0;
      for (int i = 0; i < 6; i++) sent[i] = 8'($urandom);
      do_reset();
      for (int cyc = 0; cyc < 40 && !(idx == 6 && got.size() == 6); cyc++) begin
         out_ready = N'($urandom);
         out_ready[2] = !(cyc >= 3 && cyc <= 6);
         if (idx < 6) drive(1, sent[idx], idx == 5, 2); else drive(0, 8'h00, 0, 0);
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL bp_cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
         end
         if (cyc == 3) held = out_data;
         if (cyc >= 3 && cyc <= 6) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 5'b00100 || out_data !== held) begin
               fails++; $display("FAIL bp_stall_cyc%0d: got rdy=%b vld=%b data=%h want 0 00100 %h",
                                 cyc, in_ready, out_valid, out_data, held);
            end
         end
         if (out_valid[2] && out_ready[2]) got.push_back(out_data);
         step();
         if (m_acc) idx++;
      end
      tests++;
      if (got.size() != 6) begin
         fails++; $display("FAIL bp_count: got %0d beats want 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (got[i] !== sent[i]) begin
               fails++; $display("FAIL bp_order_%0d: got %h want %h", i, got[i], sent[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int chs[4] = '{0, 3, 1, 2};
      do_reset();
      out_ready = '1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1, 8'(8'hB0 + i), 1, chs[i]); else drive(0, 8'h00, 0, 0);
         #1;
         if (i > 0) begin
            tests++;
            if (out_valid !== N'(1 << chs[i-1]) || out_data !== 8'(8'hB0 + i - 1) || !out_last) begin
               fails++; $display("FAIL b2b_%0d: got vld=%b data=%h want %b %h",
                                 i - 1, out_valid, out_data, N'(1 << chs[i-1]), 8'(8'hB0 + i - 1));
            end
         end
         if (i < 4) begin
            tests++;
            if (in_ready !== 1'b1) begin
               fails++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready);
            end
         end
         step();
      end
   endtask

   task automatic test_drop();
      do_reset();
      out_ready = '1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'($urandom), i == 3, (i == 0) ? 6 : int'($urandom_range(0, 7)));
         #1;
         tests++;
         if (in_ready !== 1'b1 || out_valid !== '0) begin
            fails++; $display("FAIL drop_beat_%0d: got rdy=%b vld=%b want 1 00000", i, in_ready, out_valid);
         end
         step();
      end
      drive(1, 8'h4D, 1, 4); #1;
      tests++;
      if (drop_cnt !== 8'd4 || out_valid !== '0) begin
         fails++; $display("FAIL drop_count: got cnt=%0d vld=%b want 4 00000", drop_cnt, out_valid);
      end
      step();
      in_valid = 0; #1;
      tests++;
      if (out_valid !== 5'b10000 || out_data !== 8'h4D) begin
         fails++; $display("FAIL drop_next_ch4: got vld=%b data=%h want 10000 4d", out_valid, out_data);
      end
      step();
   endtask

   task automatic test_saturation();
      int exp_sat[6] = '{1, 2, 3, 3, 3, 3};
      do_reset();
      out_ready = '1;
      for (int i = 0; i < 6; i++) begin
         drive(1, 8'($urandom), i == 5, 7);
         step();
         #1;
         tests++;
         if (int'(s_drop_cnt) != exp_sat[i]) begin
            fails++; $display("FAIL sat_%0d: got %0d want %0d", i, s_drop_cnt, exp_sat[i]);
         end
      end
      in_valid = 0;
      tests++;
      if (drop_cnt !== 8'd6) begin
         fails++; $display("FAIL sat_wide_cnt: got %0d want 6", drop_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         out_ready = N'($urandom) | N'($urandom);
         drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
               int'($urandom_range(0, 7)));
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL random_cyc%0d: got %h want %h", cyc, obs_vec(), exp_vec());
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_route_lock();
      test_back_pressure();
      test_back_to_back();
      test_drop();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
